// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt memory port between NUM_REQ requesters, with in-order ID FIFO for response routing.
// Optional per-requester grant and stall counters under `define MEM_ARB_PERF_CNT_EN.
module mem_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   add_i,
  input  logic [NUM_REQ-1:0]          wen_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] be_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_req_o,
  output logic [ADDR_W-1:0]           mem_add_o,
  output logic                        mem_wen_o,
  output logic [DATA_W/8-1:0]         mem_be_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  output logic                        err_o
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]       grant_cnt_o,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int AW    = $clog2(MAX_OUTST);
  localparam int CNT_W = AW + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] id_q [MAX_OUTST];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             any_req, found, full, empty, can_issue;
  logic             push, pop;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx_l;
  int               idx;

  // Scan from the priority pointer upward with wrap-around; first set request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_l = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_l = PTR_W'(idx);
      if (!found && req_i[idx_l]) begin
        found = 1'b1;
        win   = idx_l;
      end
    end
  end

  assign any_req   = |req_i;
  assign full      = (cnt_q == CNT_W'(MAX_OUTST));
  assign empty     = (cnt_q == '0);
  assign can_issue = ~full | mem_rvalid_i;
  assign mem_req_o = any_req & can_issue;
  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & ~empty;

  always_comb begin
    mem_add_o   = '0;
    mem_wen_o   = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;
    if (found) begin
      mem_add_o   = add_i[win*ADDR_W +: ADDR_W];
      mem_wen_o   = wen_i[win];
      mem_be_o    = be_i[win*BE_W +: BE_W];
      mem_wdata_o = wdata_i[win*DATA_W +: DATA_W];
    end
    if (push) gnt_o[win] = 1'b1;
    if (pop) rvalid_o[id_q[rd_q]] = 1'b1;
  end

  assign rdata_o = mem_rdata_i;
  assign err_o   = err_q;

  always_comb begin
    ptr_d = ptr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    err_d = err_q | (mem_rvalid_i & empty);
    if (push) begin
      ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      wr_d  = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // ID storage needs no reset: entries are only read while the occupancy says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) id_q[wr_q] <= win;
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] gcnt_q [NUM_REQ];
  logic [31:0] stall_q;
  logic        stall;

  assign stall = any_req & ~push;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_o[i] && gcnt_q[i] != '1) gcnt_q[i] <= gcnt_q[i] + 32'd1;
      end
      if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt_o[i*32 +: 32] = gcnt_q[i];
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: queue-based reference model checked every cycle plus directed scenarios.
module tb_mem_rr_arbiter;
  localparam int NR = 4;
  localparam int AWD = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]        req = '0;
  logic [NR*AWD-1:0]    add = '0;
  logic [NR-1:0]        wen = '0;
  logic [NR*DW/8-1:0]   be = '0;
  logic [NR*DW-1:0]     wdata = '0;
  logic                 mem_gnt = 1'b0;
  logic                 mem_rvalid = 1'b0;
  logic [DW-1:0]        mem_rdata = '0;

  logic [NR-1:0]        gnt_o, rvalid_o;
  logic [DW-1:0]        rdata_o;
  logic                 mem_req_o, mem_wen_o, err_o;
  logic [AWD-1:0]       mem_add_o;
  logic [DW/8-1:0]      mem_be_o;
  logic [DW-1:0]        mem_wdata_o;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [NR*32-1:0]     grant_cnt_o;
  logic [31:0]          stall_cnt_o;
`endif

  mem_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AWD), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .add_i(add), .wen_i(wen), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_add_o(mem_add_o), .mem_wen_o(mem_wen_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .err_o(err_o)
`ifdef MEM_ARB_PERF_CNT_EN
    , .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: priority pointer, queue of outstanding requester IDs, sticky error.
  int          m_ptr;
  int          m_q[$];
  bit          m_err;
  bit          started = 1'b0;
  int unsigned m_gcnt[NR];
  int unsigned m_stall;

  function automatic int mwin();
    for (int k = 0; k < NR; k++) begin
      if (req[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    bit any, acc;
    int w;
    if (!rst_n) begin
      m_ptr = 0;
      m_q.delete();
      m_err = 1'b0;
      started = 1'b1;
      for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
      m_stall = 0;
    end else if (started) begin
      any = |req;
      acc = any && (m_q.size() < MO || mem_rvalid) && mem_gnt;
      w = mwin();
      if (mem_rvalid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (acc) begin
        m_q.push_back(w);
        m_ptr = (w + 1) % NR;
        m_gcnt[w]++;
      end
      if (any && !acc) m_stall++;
    end
  end

  always @(negedge clk) begin
    bit any, mreq;
    int w;
    if (started) begin
      any  = |req;
      mreq = any && (m_q.size() < MO || mem_rvalid);
      w    = mwin();
      chk("mem_req", mem_req_o, mreq);
      chk("mem_add", mem_add_o, any ? add[w*AWD +: AWD] : 0);
      chk("mem_wen", mem_wen_o, any ? wen[w] : 0);
      chk("mem_be", mem_be_o, any ? be[w*DW/8 +: DW/8] : 0);
      chk("mem_wdata", mem_wdata_o, any ? wdata[w*DW +: DW] : 0);
      chk("gnt", gnt_o, (mreq && mem_gnt) ? (1 << w) : 0);
      chk("rvalid", rvalid_o, (mem_rvalid && m_q.size() > 0) ? (1 << m_q[0]) : 0);
      chk("rdata", rdata_o, mem_rdata);
      chk("err", err_o, m_err);
`ifdef MEM_ARB_PERF_CNT_EN
      for (int i = 0; i < NR; i++) chk("grant_cnt", grant_cnt_o[i*32 +: 32], m_gcnt[i]);
      chk("stall_cnt", stall_cnt_o, m_stall);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    cyc();
    @(negedge clk);
    chk("rst_err", err_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_add", mem_add_o, 0);
    cyc();
    rst_n = 1'b1;
  endtask

  int g;

  initial begin
    reset_dut();

    // Single read: grant same cycle, response two cycles later.
    req = 4'b0001; add[31:0] = 32'h10; wen = 4'b0001; mem_gnt = 1'b1;
    @(negedge clk);
    chk("t1_gnt", gnt_o, 4'b0001);
    chk("t1_add", mem_add_o, 32'h10);
    cyc();
    req = '0;
    @(negedge clk);
    chk("t1_no_rvalid", rvalid_o, 0);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h100;
    @(negedge clk);
    chk("t1_rvalid", rvalid_o, 4'b0001);
    chk("t1_rdata", rdata_o, 32'h100);
    chk("t1_err", err_o, 0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Fairness: all four requesting, 8 transfers.
    reset_dut();
    for (int i = 0; i < NR; i++) add[i*AWD +: AWD] = 32'h1000 + i;
    wen = 4'b1111; req = 4'b1111; mem_gnt = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mem_rvalid = (k > 0);
      @(negedge clk);
      chk("t2_gnt_order", gnt_o, 1 << (k % 4));
      if (k > 0) chk("t2_rvalid_order", rvalid_o, 1 << ((k - 1) % 4));
      cyc();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    chk("t2_ptr_wrapped", mem_add_o, 32'h1000);
    chk("t2_last_rvalid", rvalid_o, 4'b1000);
    chk("t2_no_gnt", gnt_o, 0);
    cyc();
    req = '0; mem_rvalid = 1'b0;

    // Backpressure: FIFO of 4 fills, then one response reopens issue in the same cycle.
    reset_dut();
    req = 4'b0011; mem_gnt = 1'b1;
    g = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (gnt_o != 0) g++;
      if (k >= 4) chk("t3_req_gated", mem_req_o, 0);
      cyc();
    end
    chk("t3_grant_count", g, 4);
    mem_rvalid = 1'b1; mem_rdata = 32'hAA;
    @(negedge clk);
    chk("t3_req_reopen", mem_req_o, 1);
    chk("t3_fifth_gnt", gnt_o, 4'b0001);
    chk("t3_pop_rvalid", rvalid_o, 4'b0001);
    cyc();
    req = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_drain", rvalid_o, (k % 2 == 0) ? 4'b0010 : 4'b0001);
      cyc();
    end
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Response routing: write by 2, read-backs by 0 and 3.
    req = 4'b0100; wen = 4'b0000; add[2*AWD +: AWD] = 32'h40;
    wdata[2*DW +: DW] = 32'h200; be[2*4 +: 4] = 4'hF;
    @(negedge clk);
    chk("t4_gnt2", gnt_o, 4'b0100);
    chk("t4_wen", mem_wen_o, 0);
    chk("t4_wdata", mem_wdata_o, 32'h200);
    chk("t4_be", mem_be_o, 4'hF);
    cyc();
    req = 4'b0001; wen = 4'b0001; add[0 +: AWD] = 32'h40;
    @(negedge clk);
    chk("t4_gnt0", gnt_o, 4'b0001);
    chk("t4_add0", mem_add_o, 32'h40);
    cyc();
    req = 4'b1000; wen = 4'b1001; add[3*AWD +: AWD] = 32'h40;
    @(negedge clk);
    chk("t4_gnt3", gnt_o, 4'b1000);
    cyc();
    req = '0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    chk("t4_rv2", rvalid_o, 4'b0100);
    cyc();
    mem_rdata = 32'h200;
    @(negedge clk);
    chk("t4_rv0", rvalid_o, 4'b0001);
    chk("t4_rd0", rdata_o, 32'h200);
    cyc();
    @(negedge clk);
    chk("t4_rv3", rvalid_o, 4'b1000);
    chk("t4_rd3", rdata_o, 32'h200);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Spurious response with empty FIFO.
    mem_rvalid = 1'b1; mem_rdata = 32'h5;
    @(negedge clk);
    chk("t5_no_rvalid", rvalid_o, 0);
    chk("t5_err_pre", err_o, 0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("t5_err_set", err_o, 1);
    cyc();
    @(negedge clk);
    chk("t5_err_sticky", err_o, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_err_cleared", err_o, 0);
    cyc();

`ifdef MEM_ARB_PERF_CNT_EN
    reset_dut();
    req = 4'b0010; mem_gnt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = (k > 0);
      cyc();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    req = '0; mem_rvalid = 1'b1;
    @(negedge clk);
    chk("t6_grant_cnt1", grant_cnt_o[63:32], 3);
    chk("t6_grant_cnt0", grant_cnt_o[31:0], 0);
    chk("t6_stall_cnt", stall_cnt_o, 5);
    cyc();
    mem_rvalid = 1'b0;
`endif

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
